// File: rtl/pipelined_ks_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipelined_ks_adder
// Purpose  : Fully pipelined Kogge-Stone adder/subtractor with a single global
//            advance enable and valid/ready handshakes on both sides.
//            Latency is LEVELS+2 cycles and throughput is one result per cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : operand set valid
//   in_ready   : block accepts an operand set this cycle (= advance enable)
//   in_a, in_b : operands, WIDTH bits
//   in_cin     : carry-in (add mode only)
//   in_sub     : 1 = a - b, 0 = a + b + cin
//   out_valid  : result valid
//   out_ready  : downstream accepts the result
//   sum        : result modulo 2^WIDTH
//   cout       : carry out of the MSB (no-borrow flag when subtracting)
//   ovf        : two's-complement signed overflow
//   zero       : sum == 0
// ============================================================================
module pipelined_ks_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int LEVELS = $clog2(WIDTH);

    // Prefix vectors are WIDTH+1 bits wide: index 0 is the carry-in treated as
    // the generate of position -1, index j holds position j-1. After the final
    // level, gen_q[LEVELS][j] is therefore the carry out of position j-1.
    logic [WIDTH:0]   gen_q   [0:LEVELS];
    logic [WIDTH:0]   gen_d   [0:LEVELS];
    logic [WIDTH:0]   prop_q  [0:LEVELS];
    logic [WIDTH:0]   prop_d  [0:LEVELS];
    logic [WIDTH-1:0] xor_q   [0:LEVELS];
    logic [WIDTH-1:0] xor_d   [0:LEVELS];
    logic             sa_q    [0:LEVELS];
    logic             sa_d    [0:LEVELS];
    logic             sb_q    [0:LEVELS];
    logic             sb_d    [0:LEVELS];
    logic             valid_q [0:LEVELS];
    logic             valid_d [0:LEVELS];

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             out_valid_q;

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic             w_c_msb_in;
    logic             w_unused;

    assign w_adv     = !out_valid_q || out_ready;
    assign in_ready  = w_adv;
    assign w_b_eff   = in_b ^ {WIDTH{in_sub}};
    assign w_cin_eff = in_sub | in_cin;

    // Carry into the MSB, i.e. C[WIDTH-2].
    assign w_c_msb_in = gen_q[LEVELS][WIDTH-1];

    // Position WIDTH-1's own prefix is not needed: cout is rebuilt from the
    // carried MSB operand bits, so the top prefix bit and the final-level
    // group propagates are intentionally left unused.
    assign w_unused = ^{prop_q[LEVELS], gen_q[LEVELS][WIDTH]};

    always_comb begin
        gen_d[0]   = {in_a & w_b_eff, w_cin_eff};
        prop_d[0]  = {in_a ^ w_b_eff, 1'b0};
        xor_d[0]   = in_a ^ w_b_eff;
        sa_d[0]    = in_a[WIDTH-1];
        sb_d[0]    = w_b_eff[WIDTH-1];
        valid_d[0] = in_valid;
        for (int k = 1; k <= LEVELS; k++) begin
            // Shifting in zeros makes positions with no partner below -1 pass
            // through: their generate is kept, and their group propagate is
            // already 0 because it spans the carry-in position.
            gen_d[k]   = gen_q[k-1] | (prop_q[k-1] & (gen_q[k-1] << (1 << (k-1))));
            prop_d[k]  = prop_q[k-1] & (prop_q[k-1] << (1 << (k-1)));
            xor_d[k]   = xor_q[k-1];
            sa_d[k]    = sa_q[k-1];
            sb_d[k]    = sb_q[k-1];
            valid_d[k] = valid_q[k-1];
        end
        sum_d  = xor_q[LEVELS] ^ gen_q[LEVELS][WIDTH-1:0];
        cout_d = (sa_q[LEVELS] & sb_q[LEVELS]) | (xor_q[LEVELS][WIDTH-1] & w_c_msb_in);
        ovf_d  = cout_d ^ w_c_msb_in;
        zero_d = ~|sum_d;
    end

    // Control and output registers: reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= LEVELS; k++) begin
                valid_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k <= LEVELS; k++) begin
                valid_q[k] <= valid_d[k];
            end
            out_valid_q <= valid_q[LEVELS];
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    // Internal datapath registers: no reset, qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int k = 0; k <= LEVELS; k++) begin
                gen_q[k]  <= gen_d[k];
                prop_q[k] <= prop_d[k];
                xor_q[k]  <= xor_d[k];
                sa_q[k]   <= sa_d[k];
                sb_q[k]   <= sb_d[k];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_ks_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_ks_adder
// Purpose  : Self-checking bench for pipelined_ks_adder: reset, directed
//            corner cases, backpressured streaming, mid-flight reset and a
//            width sweep, all against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_ks_adder;

    localparam int W   = 16;
    localparam int LAT = 6;
    localparam int NSW = 5;
    localparam int SWC = 1150;
    localparam int SWT = SWC + 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready, in_cin, in_sub;
    logic [W-1:0]  in_a, in_b;
    logic          out_valid, out_ready;
    logic [W-1:0]  sum;
    logic          cout, ovf, zero;

    int n_cmp = 0;
    int n_bad = 0;

    pipelined_ks_adder #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    // Width-sweep instances share one 64-bit stimulus bus.
    logic        sw_valid, sw_cin, sw_sub;
    logic [63:0] sw_a, sw_b;
    logic        sw_ir [NSW];
    logic        sw_ov [NSW];
    logic        sw_co [NSW];
    logic        sw_of [NSW];
    logic        sw_z  [NSW];
    logic [63:0] sw_sum [NSW];

    function automatic int sw_width(input int n);
        case (n)
            0:       return 2;
            1:       return 5;
            2:       return 16;
            3:       return 33;
            default: return 64;
        endcase
    endfunction

    function automatic int lat_of(input int w);
        int l = 0;
        while ((1 << l) < w) l++;
        return l + 2;
    endfunction

    for (genvar n = 0; n < NSW; n++) begin : g_sweep
        localparam int SW = (n == 0) ? 2 : (n == 1) ? 5 : (n == 2) ? 16 : (n == 3) ? 33 : 64;
        logic [SW-1:0] s;
        pipelined_ks_adder #(.WIDTH(SW)) u_sw (
            .clk(clk), .rst(rst),
            .in_valid(sw_valid), .in_ready(sw_ir[n]),
            .in_a(sw_a[SW-1:0]), .in_b(sw_b[SW-1:0]), .in_cin(sw_cin), .in_sub(sw_sub),
            .out_valid(sw_ov[n]), .out_ready(1'b1),
            .sum(s), .cout(sw_co[n]), .ovf(sw_of[n]), .zero(sw_z[n])
        );
        assign sw_sum[n] = 64'(s);
    end

    // Reference: plain unsigned/signed integer arithmetic at width w.
    function automatic void model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                  input bit sub, input bit cin,
                                  output logic [63:0] s, output logic co, output logic ov, output logic z);
        logic [63:0]        mask, a, b;
        logic signed [67:0] sa, sb, r, hi, lo;
        logic [67:0]        u;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a  = a_in & mask;
        b  = b_in & mask;
        sa = $signed({4'b0, a});
        sb = $signed({4'b0, b});
        if (a[w-1]) sa = sa - (68'sd1 <<< w);
        if (b[w-1]) sb = sb - (68'sd1 <<< w);
        hi = (68'sd1 <<< (w-1)) - 68'sd1;
        lo = -(68'sd1 <<< (w-1));
        if (sub) begin
            r  = sa - sb;
            s  = (a - b) & mask;
            co = (a >= b);
        end else begin
            r  = sa + sb + 68'(cin);
            u  = {4'b0, a} + {4'b0, b} + 68'(cin);
            s  = u[63:0] & mask;
            co = u[w];
        end
        ov = (r > hi) || (r < lo);
        z  = (s == 64'd0);
    endfunction

    // Issue one operand set to the main DUT (pipeline idle, out_ready=1) and
    // wait, bounded, for its result.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit cin, input bit sub,
                         output logic [W-1:0] s, output logic co, output logic ov, output logic z,
                         output int lat);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        s = sum; co = cout; ov = ovf; z = zero;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, sum, cout, ovf, zero} !== {1'b0, 1'b1, 16'h0, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_state: got ov=%b ir=%b sum=%h c=%b o=%b z=%b, want ov=0 ir=1 sum=0000 c=0 o=0 z=0",
                     out_valid, in_ready, sum, cout, ovf, zero);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        bit           tc [4];
        bit           ts [4];
        logic [18:0]  te [4];
        logic [W-1:0] s;
        logic         co, ov, z;
        int           lat;
        ta[0] = 16'h7FFF; tb[0] = 16'h0001; tc[0] = 0; ts[0] = 0; te[0] = {16'h8000, 3'b010};
        ta[1] = 16'h0005; tb[1] = 16'h0005; tc[1] = 0; ts[1] = 1; te[1] = {16'h0000, 3'b101};
        ta[2] = 16'h0000; tb[2] = 16'h0001; tc[2] = 0; ts[2] = 1; te[2] = {16'hFFFF, 3'b000};
        ta[3] = 16'hFFFF; tb[3] = 16'h0000; tc[3] = 1; ts[3] = 0; te[3] = {16'h0000, 3'b101};
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], tc[i], ts[i], s, co, ov, z, lat);
            n_cmp++;
            if (lat !== LAT) begin
                n_bad++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, want %0d", i, lat, LAT);
            end
            n_cmp++;
            if ({s, co, ov, z} !== te[i]) begin
                n_bad++;
                $display("FAIL directed_result[%0d]: got sum=%h c=%b o=%b z=%b, want sum=%h c=%b o=%b z=%b",
                         i, s, co, ov, z, te[i][18:3], te[i][2], te[i][1], te[i][0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] ra [20];
        logic [W-1:0] rb [20];
        bit           rc [20];
        bit           rs [20];
        logic [18:0]  exp_q [$];
        logic [18:0]  held_val, e;
        logic [63:0]  ms;
        logic         mco, mov, mz, held, exp_ir;
        int           sent, got, cyc;
        for (int i = 0; i < 20; i++) begin
            ra[i] = W'($urandom); rb[i] = W'($urandom);
            rc[i] = 1'($urandom); rs[i] = 1'($urandom);
        end
        sent = 0; got = 0; cyc = 0; held = 1'b0; held_val = '0;
        while (got < 20 && cyc < 300) begin
            out_ready = !(cyc >= 10 && cyc < 13);
            if (sent < 20) begin
                in_valid = 1'b1;
                in_a = ra[sent]; in_b = rb[sent]; in_cin = rc[sent]; in_sub = rs[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) begin
                n_cmp++;
                if ({out_valid, sum, cout, ovf, zero} !== {1'b1, held_val}) begin
                    n_bad++;
                    $display("FAIL stall_hold cyc%0d: got v=%b %h, want v=1 %h", cyc, out_valid,
                             {sum, cout, ovf, zero}, held_val);
                end
            end
            exp_ir = !out_valid || out_ready;
            n_cmp++;
            if (in_ready !== exp_ir) begin
                n_bad++;
                $display("FAIL in_ready cyc%0d: got %b, want %b", cyc, in_ready, exp_ir);
            end
            if (in_valid && in_ready) begin
                model(W, 64'(ra[sent]), 64'(rb[sent]), rs[sent], rc[sent], ms, mco, mov, mz);
                exp_q.push_back({ms[W-1:0], mco, mov, mz});
                sent++;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream_extra cyc%0d: got result %h, want none", cyc, {sum, cout, ovf, zero});
                end else begin
                    e = exp_q.pop_front();
                    if ({sum, cout, ovf, zero} !== e) begin
                        n_bad++;
                        $display("FAIL stream_result[%0d]: got %h, want %h", got, {sum, cout, ovf, zero}, e);
                    end
                end
                got++;
            end
            held = out_valid && !out_ready;
            held_val = {sum, cout, ovf, zero};
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++;
        if (got != 20 || sent != 20) begin
            n_bad++;
            $display("FAIL stream_count: got %0d results from %0d sent, want 20 from 20", got, sent);
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_flush;
        logic [W-1:0] s, a, b;
        logic [63:0]  ms;
        logic         co, ov, z, mco, mov, mz;
        bit           c, sb;
        int           lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom); in_sub = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_first_valid: got out_valid=%b, want 1", out_valid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, sum, cout, ovf, zero, in_ready} !== {1'b0, 16'h0, 3'b000, 1'b1}) begin
            n_bad++;
            $display("FAIL flush_async_clear: got v=%b sum=%h c=%b o=%b z=%b ir=%b, want all 0, ir=1",
                     out_valid, sum, cout, ovf, zero, in_ready);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL flush_ghost cyc%0d: got out_valid=%b, want 0", i, out_valid);
            end
            @(posedge clk); #1;
        end
        a = W'($urandom); b = W'($urandom); c = 1'($urandom); sb = 1'($urandom);
        do_op(a, b, c, sb, s, co, ov, z, lat);
        model(W, 64'(a), 64'(b), sb, c, ms, mco, mov, mz);
        n_cmp++;
        if (lat !== LAT) begin
            n_bad++;
            $display("FAIL flush_latency: got %0d cycles, want %0d", lat, LAT);
        end
        n_cmp++;
        if ({s, co, ov, z} !== {ms[W-1:0], mco, mov, mz}) begin
            n_bad++;
            $display("FAIL flush_result: got %h, want %h", {s, co, ov, z}, {ms[W-1:0], mco, mov, mz});
        end
        @(posedge clk); #1;
    endtask

    bit          hv [SWT];
    bit          hc [SWT];
    bit          hs [SWT];
    logic [63:0] ha [SWT];
    logic [63:0] hb [SWT];

    task automatic test_width_sweep;
        logic [63:0] ms, mask;
        logic        mco, mov, mz;
        bit          ev;
        int          w, idx;
        for (int c = 0; c < SWT; c++) begin
            hv[c] = (c < SWC) && ($urandom_range(7) != 0);
            ha[c] = {$urandom, $urandom};
            hb[c] = {$urandom, $urandom};
            hc[c] = 1'($urandom);
            hs[c] = 1'($urandom);
        end
        for (int c = 0; c < SWT; c++) begin
            for (int n = 0; n < NSW; n++) begin
                w   = sw_width(n);
                idx = c - lat_of(w);
                ev  = (idx >= 0) && hv[idx];
                n_cmp++;
                if (sw_ov[n] !== ev || sw_ir[n] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL sweep_valid w%0d cyc%0d: got v=%b ir=%b, want v=%b ir=1",
                             w, c, sw_ov[n], sw_ir[n], ev);
                end
                if (ev) begin
                    model(w, ha[idx], hb[idx], hs[idx], hc[idx], ms, mco, mov, mz);
                    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
                    n_cmp++;
                    if ({sw_sum[n] & mask, sw_co[n], sw_of[n], sw_z[n]} !== {ms, mco, mov, mz}) begin
                        n_bad++;
                        $display("FAIL sweep_result w%0d op%0d: got sum=%h c=%b o=%b z=%b, want sum=%h c=%b o=%b z=%b",
                                 w, idx, sw_sum[n], sw_co[n], sw_of[n], sw_z[n], ms, mco, mov, mz);
                    end
                end
            end
            sw_valid = hv[c]; sw_a = ha[c]; sw_b = hb[c]; sw_cin = hc[c]; sw_sub = hs[c];
            @(posedge clk); #1;
        end
        sw_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
        test_reset;
        test_directed;
        test_back_to_back;
        test_reset_flush;
        test_width_sweep;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
